// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: one handshaked bus transaction per load/store,
// with store lane steering, load extension, misalignment and timeout faults.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  inst_size,
  input  logic        is_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StFault} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_cause_q, fault_cause_d;
  // Access shape kept for the load extraction at ack time.
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;

  logic        req, mis;
  logic [3:0]  be;
  logic [31:0] wd_lanes, lane, load_ext;
  logic [7:0]  cnt_inc;

  assign req     = mem_read | mem_write;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    mis      = 1'b0;
    be       = 4'b1111;
    wd_lanes = wdata;
    unique case (inst_size)
      SizeByte: begin
        be       = 4'b0001 << addr[1:0];
        wd_lanes = {4{wdata[7:0]}};
      end
      SizeHalf: begin
        mis      = addr[0];
        be       = 4'b0011 << addr[1:0];
        wd_lanes = {2{wdata[15:0]}};
      end
      default: mis = |addr[1:0];
    endcase
  end

  always_comb begin
    lane     = bus_rdata >> {off_q, 3'b000};
    load_ext = lane;
    unique case (size_q)
      SizeByte: load_ext = {{24{sign_q & lane[7]}}, lane[7:0]};
      SizeHalf: load_ext = {{16{sign_q & lane[15]}}, lane[15:0]};
      default:  load_ext = lane;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    rdata_d       = rdata_q;
    done_d        = 1'b0;
    fault_d       = 1'b0;
    fault_cause_d = fault_cause_q;
    size_d        = size_q;
    sign_d        = sign_q;
    off_d         = off_q;
    unique case (state_q)
      StIdle: begin
        if (req && mis) begin
          state_d       = StFault;
          fault_d       = 1'b1;
          fault_cause_d = 2'b01;
        end else if (req) begin
          state_d     = StAccess;
          cnt_d       = 8'd0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = be;
          bus_wdata_d = wd_lanes;
          size_d      = inst_size;
          sign_d      = is_signed;
          off_d       = addr[1:0];
        end
      end
      StAccess: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          state_d   = StDone;
          done_d    = 1'b1;
          bus_req_d = 1'b0;
          if (!bus_we_q) rdata_d = load_ext;
        end else if (cnt_inc == TimeoutCnt) begin
          state_d       = StFault;
          cnt_d         = cnt_inc;
          fault_d       = 1'b1;
          fault_cause_d = 2'b10;
          bus_req_d     = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'd0;
      bus_be_q      <= 4'd0;
      bus_wdata_q   <= 32'd0;
      rdata_q       <= 32'd0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'b00;
      size_q        <= 2'b00;
      sign_q        <= 1'b0;
      off_q         <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      rdata_q       <= rdata_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      size_q        <= size_d;
      sign_q        <= sign_d;
      off_q         <= off_d;
    end
  end

  assign stall       = reset & (((state_q == StIdle) & req) | (state_q == StAccess));
  assign rdata       = rdata_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl against a transaction-level reference model.
module tb_dmem_access_ctrl;

  localparam int unsigned To = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, is_signed;
  logic [1:0]  inst_size;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_cause;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rdata = 32'd0;
  logic [1:0]  exp_cause = 2'b00;

  dmem_access_ctrl #(.TIMEOUT(To)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .inst_size  (inst_size),
    .is_signed  (is_signed),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .done       (done),
    .fault      (fault),
    .fault_cause(fault_cause),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one access from an idle cycle; entered and left at 1 time unit after a rising edge.
  // ack_delay = wait cycles before ack; ack_delay >= To means the bus never answers in time.
  task automatic run_access(input string tag, input bit we, input logic [1:0] size,
                            input bit sgn, input logic [31:0] a, input logic [31:0] wd,
                            input int ack_delay, input logic [31:0] rword);
    int off, nbytes, kind, end_cyc, n_stall, n_req, n_done, n_fault;
    logic [31:0] e_be, e_wd, lane, v;
    off    = int'(a % 4);
    nbytes = 1 << size;
    e_be   = ((32'd1 << nbytes) - 32'd1) << off;
    if (nbytes == 1)      e_wd = (wd & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) e_wd = (wd & 32'hFFFF) * 32'h0001_0001;
    else                  e_wd = wd;
    if ((off % nbytes) != 0) begin kind = 0; end_cyc = 1; end
    else if (ack_delay < int'(To)) begin kind = 1; end_cyc = ack_delay + 2; end
    else begin kind = 2; end_cyc = int'(To) + 1; end
    lane = rword >> (8 * off);
    if (nbytes == 1) begin
      v = lane & 32'hFF;
      if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (nbytes == 2) begin
      v = lane & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = lane;
    end

    mem_write = we;
    mem_read  = we ? 1'($urandom % 2) : 1'b1;
    inst_size = size;
    is_signed = sgn;
    addr      = a;
    wdata     = wd;
    bus_rdata = rword;
    n_stall = 0; n_req = 0; n_done = 0; n_fault = 0;
    for (int c = 0; c <= end_cyc + 1; c++) begin
      if (c == end_cyc + 1) begin
        mem_read = 1'b0; mem_write = 1'b0; addr = $urandom;
      end
      if (c > 0 && c < end_cyc) bus_ack = (kind == 1) && (c == end_cyc - 1);
      else bus_ack = 1'($urandom % 2);
      #1;
      n_stall += int'(stall); n_req += int'(bus_req);
      n_done  += int'(done);  n_fault += int'(fault);
      if (c == 1 && kind != 0) begin
        check_eq({tag, ".bus_we"}, 32'(bus_we), 32'(we));
        check_eq({tag, ".bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
        check_eq({tag, ".bus_be"}, 32'(bus_be), e_be);
        if (we) check_eq({tag, ".bus_wdata"}, bus_wdata, e_wd);
      end
      if (c == end_cyc) begin
        if (kind == 0) exp_cause = 2'b01;
        if (kind == 2) exp_cause = 2'b10;
        if (kind == 1 && !we) exp_rdata = v;
        check_eq({tag, ".done"}, 32'(done), 32'(kind == 1));
        check_eq({tag, ".fault"}, 32'(fault), 32'(kind != 1));
        check_eq({tag, ".cause"}, 32'(fault_cause), 32'(exp_cause));
        check_eq({tag, ".rdata"}, rdata, exp_rdata);
      end
      if (c == end_cyc + 1) check_eq({tag, ".idle_after"}, {30'd0, bus_req, stall}, 32'd0);
      @(posedge clk); #1;
    end
    check_eq({tag, ".stall_cycles"}, 32'(n_stall), 32'(end_cyc));
    check_eq({tag, ".req_cycles"}, 32'(n_req), 32'(kind == 0 ? 0 : end_cyc - 1));
    check_eq({tag, ".done_pulses"}, 32'(n_done), 32'(kind == 1));
    check_eq({tag, ".fault_pulses"}, 32'(n_fault), 32'(kind != 1));
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0; inst_size = 2'b10; is_signed = 1'b0;
    addr = 32'h100; wdata = 32'd0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.stall", 32'(stall), 32'd0);
    check_eq("rst.ctrl", {22'd0, bus_req, bus_we, done, fault, fault_cause, bus_be}, 32'd0);
    check_eq("rst.bus_addr", bus_addr, 32'd0);
    check_eq("rst.bus_wdata", bus_wdata, 32'd0);
    check_eq("rst.rdata", rdata, 32'd0);
    mem_read = 1'b0; bus_ack = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    run_access("lw_aligned", 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 0, 32'hDEAD_BEEF);
    run_access("lb_signed", 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 0, 32'h80FF_1234);
    run_access("lbu", 1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 1, 32'h80FF_1234);
    run_access("sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 3, 32'h1111_2222);
    run_access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 0, 32'h5555_AAAA);
    run_access("timeout", 1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 99, 32'h1234_5678);
    run_access("after_to", 1'b0, 2'b01, 1'b1, 32'h206, 32'd0, 0, 32'h9ABC_0000);
    run_access("ack_4th", 1'b0, 2'b10, 1'b0, 32'h300, 32'd0, int'(To) - 1, 32'hCAFE_F00D);

    // Reset in the middle of an access, followed by a late ack.
    mem_read = 1'b1; mem_write = 1'b0; inst_size = 2'b10; addr = 32'h40; bus_ack = 1'b0;
    @(posedge clk); #1;
    check_eq("mid.req_before", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("mid.drop", {30'd0, bus_req, stall}, 32'd0);
    check_eq("mid.ctrl", {22'd0, bus_req, bus_we, done, fault, fault_cause, bus_be}, 32'd0);
    check_eq("mid.bus_addr", bus_addr, 32'd0);
    check_eq("mid.rdata", rdata, 32'd0);
    exp_rdata = 32'd0; exp_cause = 2'b00;
    mem_read = 1'b0; bus_ack = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    begin
      int n_done = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        n_done += int'(done) + int'(bus_req);
      end
      check_eq("mid.late_ack", 32'(n_done), 32'd0);
    end
    bus_ack = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 2));
      run_access("rand", 1'($urandom % 2), sz, 1'($urandom % 2), $urandom, $urandom,
                 int'($urandom_range(0, To + 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
